// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serializing arbiter between IF/MEM and the byte-wide unified RAM
module mem_ctrl #(
  parameter int AddrLen = 32,
  parameter int RegLen  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               if_req,
  input  logic [AddrLen-1:0] if_addr,
  output logic               if_done,
  output logic [RegLen-1:0]  if_data,
  input  logic               load_or_not,
  input  logic               store_or_not,
  input  logic [AddrLen-1:0] mem_addr,
  input  logic [2:0]         num_of_bytes,
  input  logic [RegLen-1:0]  store_data,
  output logic               mem_enable,
  output logic [RegLen-1:0]  load_data,
  input  logic [7:0]         ram_din,
  output logic [7:0]         ram_dout,
  output logic [AddrLen-1:0] ram_a,
  output logic               ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e               state_q, state_d;
  logic [AddrLen-1:0]   base_q, base_d;
  logic [2:0]           n_q, n_d;
  logic [2:0]           i_q, i_d;     // next byte to issue
  logic [2:0]           j_q, j_d;     // next byte to capture
  logic [RegLen-1:0]    sdata_q, sdata_d;
  logic                 own_mem_q, own_mem_d;
  logic [RegLen-1:0]    rbuf_q, rbuf_d;
  logic [RegLen-1:0]    if_data_q, if_data_d;
  logic [RegLen-1:0]    load_data_q, load_data_d;

  logic [RegLen-1:0]    cap_word;
  logic [7:0]           wr_byte;
  logic [AddrLen-1:0]   cur_addr;

  // Byte lane helpers: merge the incoming RAM byte at lane j, pick store byte at lane i
  always_comb begin
    cap_word = rbuf_q;
    wr_byte  = sdata_q[7:0];
    cur_addr = base_q + AddrLen'(i_q);
    case (j_q[1:0])
      2'd0:    cap_word[7:0]   = ram_din;
      2'd1:    cap_word[15:8]  = ram_din;
      2'd2:    cap_word[23:16] = ram_din;
      default: cap_word[31:24] = ram_din;
    endcase
    case (i_q[1:0])
      2'd0:    wr_byte = sdata_q[7:0];
      2'd1:    wr_byte = sdata_q[15:8];
      2'd2:    wr_byte = sdata_q[23:16];
      default: wr_byte = sdata_q[31:24];
    endcase
  end

  // Next-state, RAM port drive and result assembly
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    n_d         = n_q;
    i_d         = i_q;
    j_d         = j_q;
    sdata_d     = sdata_q;
    own_mem_d   = own_mem_q;
    rbuf_d      = rbuf_q;
    if_data_d   = if_data_q;
    load_data_d = load_data_q;
    ram_a       = '0;
    ram_dout    = '0;
    ram_wr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy) begin
          i_d    = 3'd0;
          j_d    = 3'd0;
          rbuf_d = '0;
          if (store_or_not || load_or_not) begin
            base_d    = mem_addr;
            sdata_d   = store_data;
            own_mem_d = 1'b1;
            n_d       = num_of_bytes[2] ? 3'd4 : (num_of_bytes[1] ? 3'd2 : 3'd1);
            state_d   = store_or_not ? WRITE : READ;
          end else if (if_req) begin
            base_d    = if_addr;
            own_mem_d = 1'b0;
            n_d       = 3'd4;
            state_d   = READ;
          end
        end
      end
      READ: begin
        if (i_q < n_q) ram_a = cur_addr;
        if (rdy) begin
          if (i_q < n_q) i_d = i_q + 3'd1;
          // i ahead of j means the byte addressed last cycle is on ram_din now
          if (i_q != j_q) begin
            rbuf_d = cap_word;
            j_d    = j_q + 3'd1;
            if (j_q == 3'(n_q - 3'd1)) begin
              state_d = DONE;
              if (own_mem_q) load_data_d = cap_word;
              else           if_data_d   = cap_word;
            end
          end
        end else begin
          // the byte in flight is lost while frozen; re-issue it afterwards
          i_d = j_q;
        end
      end
      WRITE: begin
        ram_a    = cur_addr;
        ram_dout = wr_byte;
        ram_wr   = rdy;
        if (rdy) begin
          i_d = i_q + 3'd1;
          if (i_q == 3'(n_q - 3'd1)) state_d = DONE;
        end
      end
      default: begin
        if (rdy) state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      n_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      sdata_q     <= '0;
      own_mem_q   <= 1'b0;
      rbuf_q      <= '0;
      if_data_q   <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      n_q         <= n_d;
      i_q         <= i_d;
      j_q         <= j_d;
      sdata_q     <= sdata_d;
      own_mem_q   <= own_mem_d;
      rbuf_q      <= rbuf_d;
      if_data_q   <= if_data_d;
      load_data_q <= load_data_d;
    end
  end

  assign if_done    = (state_q == DONE) && !own_mem_q;
  assign mem_enable = (state_q == DONE) && own_mem_q;
  assign if_data    = if_data_q;
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, if_req, load_or_not, store_or_not;
  logic [31:0] if_addr, mem_addr, store_data;
  logic [2:0]  num_of_bytes;
  logic        if_done, mem_enable, ram_wr;
  logic [31:0] if_data, load_data, ram_a;
  logic [7:0]  ram_din, ram_dout;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  ram [0:65535];
  logic [7:0]  rd_q;
  logic        bd_we = 1'b0;
  logic [15:0] bd_a = '0;
  logic [7:0]  bd_d = '0;

  logic [31:0] tr_a [0:31];
  logic        tr_wr [0:31];
  logic [7:0]  tr_do [0:31];
  int men_cyc, ifd_cyc, men_cnt, ifd_cnt;

  mem_ctrl #(.AddrLen(32), .RegLen(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .load_or_not(load_or_not), .store_or_not(store_or_not), .mem_addr(mem_addr),
    .num_of_bytes(num_of_bytes), .store_data(store_data),
    .mem_enable(mem_enable), .load_data(load_data),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we)       ram[bd_a] <= bd_d;
    else if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
    rd_q <= ram[ram_a[15:0]];
  end
  assign ram_din = rd_q;

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    bd_a = a; bd_d = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic record(input int c);
    tr_a[c] = ram_a; tr_wr[c] = ram_wr; tr_do[c] = ram_dout;
    if (mem_enable) begin men_cnt++; if (men_cyc < 0) men_cyc = c; end
    if (if_done) begin ifd_cnt++; if (ifd_cyc < 0) ifd_cyc = c; if_req = 1'b0; end
  endtask

  // Cycle 0 = IDLE cycle whose ending edge accepts; outputs sampled 2ns after each edge
  task automatic run_access(input logic st, input logic ld, input logic ifr,
                            input logic [31:0] maddr, input logic [31:0] iaddr,
                            input logic [2:0] nb, input logic [31:0] sd,
                            input int stall_at, input int stall_len,
                            input int rst_at, input int ncyc);
    men_cyc = -1; ifd_cyc = -1; men_cnt = 0; ifd_cnt = 0;
    for (int k = 0; k < 32; k++) begin tr_a[k] = '0; tr_wr[k] = 1'b0; tr_do[k] = '0; end
    @(posedge clk); #1;
    store_or_not = st; load_or_not = ld; if_req = ifr;
    mem_addr = maddr; if_addr = iaddr; num_of_bytes = nb; store_data = sd;
    #1; record(0);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      rdy = !(c >= stall_at && c < stall_at + stall_len);
      if (c == 1) begin store_or_not = 1'b0; load_or_not = 1'b0; end
      if (rst_at > 0 && c == rst_at) rst = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) rst = 1'b0;
      #1; record(c);
    end
    if_req = 1'b0; rdy = 1'b1;
  endtask

  task automatic test_reset;
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
    check("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
    check("rst_dones", {30'h0, if_done, mem_enable}, 32'h0);
    check("rst_data", if_data | load_data, 32'h0);
  endtask

  task automatic test_lw;
    run_access(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 3'b100, 32'h0, 0, 0, 0, 10);
    for (int c = 1; c <= 4; c++) check("lw_ram_a", tr_a[c], 32'h1000 + 32'(c - 1));
    check("lw_ram_a_after", tr_a[5], 32'h0);
    check("lw_done_cycle", 32'(men_cyc), 32'd6);
    check("lw_done_count", 32'(men_cnt), 32'd1);
    check("lw_no_if_done", 32'(ifd_cnt), 32'd0);
    check("lw_data", load_data, 32'h44332211);
  endtask

  task automatic test_sh;
    run_access(1'b1, 1'b0, 1'b0, 32'h2002, 32'h0, 3'b010, 32'hDEADBEEF, 0, 0, 0, 8);
    check("sh_c1", {tr_wr[1], tr_a[1][23:0], tr_do[1]}, {1'b1, 24'h002002, 8'hEF});
    check("sh_c2", {tr_wr[2], tr_a[2][23:0], tr_do[2]}, {1'b1, 24'h002003, 8'hBE});
    check("sh_c3_wr", {31'h0, tr_wr[3]}, 32'h0);
    check("sh_done_cycle", 32'(men_cyc), 32'd3);
    check("sh_ram", {8'h0, ram[16'h2002], ram[16'h2003], ram[16'h2004]}, 32'h00EFBE5A);
  endtask

  task automatic test_contention;
    run_access(1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 3'b001, 32'h0, 0, 0, 0, 14);
    check("cont_lb_addr", tr_a[1], 32'h10);
    check("cont_mem_cycle", 32'(men_cyc), 32'd3);
    check("cont_load_data", load_data, 32'h00000080);
    check("cont_if_addr", tr_a[6], 32'h1);
    check("cont_if_cycle", 32'(ifd_cyc), 32'd10);
    check("cont_if_count", 32'(ifd_cnt), 32'd1);
    check("cont_if_data", if_data, 32'hD3C2B1A0);
  endtask

  task automatic test_stall;
    int wrs;
    run_access(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 3'b100, 32'h0, 4, 3, 0, 14);
    wrs = 0;
    for (int c = 0; c <= 14; c++) if (tr_wr[c]) wrs++;
    check("stall_no_wr", 32'(wrs), 32'd0);
    check("stall_reissue", tr_a[7], 32'h1002);
    check("stall_done_cycle", 32'(men_cyc), 32'd10);
    check("stall_data", load_data, 32'h44332211);
  endtask

  task automatic test_reset_mid_load;
    run_access(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 3'b100, 32'h0, 0, 0, 2, 10);
    check("rstld_ram_a", tr_a[2], 32'h0);
    check("rstld_no_done", 32'(men_cnt), 32'd0);
    check("rstld_data", load_data, 32'h0);
  endtask

  task automatic test_reset_mid_sw;
    run_access(1'b1, 1'b0, 1'b0, 32'h3000, 32'h0, 3'b100, 32'hA1B2C3D4, 0, 0, 3, 10);
    check("rstsw_wr12", {30'h0, tr_wr[1], tr_wr[2]}, 32'h3);
    check("rstsw_wr3", {31'h0, tr_wr[3]}, 32'h0);
    check("rstsw_no_done", 32'(men_cnt), 32'd0);
    check("rstsw_ram", {ram[16'h3003], ram[16'h3002], ram[16'h3001], ram[16'h3000]}, 32'h0000C3D4);
    run_access(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 3'b100, 32'h0, 0, 0, 0, 10);
    check("rstsw_lw_cycle", 32'(men_cyc), 32'd6);
    check("rstsw_lw_data", load_data, 32'h44332211);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; if_req = 1'b0; load_or_not = 1'b0; store_or_not = 1'b0;
    if_addr = '0; mem_addr = '0; num_of_bytes = 3'b000; store_data = '0;
    #1;
    test_reset;
    poke(16'h1000, 8'h11); poke(16'h1001, 8'h22); poke(16'h1002, 8'h33); poke(16'h1003, 8'h44);
    poke(16'h2002, 8'h00); poke(16'h2003, 8'h00); poke(16'h2004, 8'h5A);
    poke(16'h0000, 8'hA0); poke(16'h0001, 8'hB1); poke(16'h0002, 8'hC2); poke(16'h0003, 8'hD3);
    poke(16'h0010, 8'h80);
    poke(16'h3000, 8'h00); poke(16'h3001, 8'h00); poke(16'h3002, 8'h00); poke(16'h3003, 8'h00);
    rst = 1'b0;
    test_lw;
    test_sh;
    test_contention;
    test_stall;
    test_reset_mid_load;
    test_reset_mid_sw;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the pipeline and the byte-wide unified RAM port. It arbitrates between instruction fetch (IF, always 4-byte reads) and the MEM stage (1/2/4-byte loads and stores). Each granted access is serialized into single-byte RAM cycles, and the assembled word is returned with a one-cycle done pulse. It sits between if/mem and the top-level RAM pins; sign extension stays in the MEM stage.

## Interface
- AddrLen, 32, address width
- RegLen, 32, data word width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global ready; low freezes the controller
- if_req  in  1  fetch request (level)
- if_addr  in  AddrLen  fetch address
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  RegLen  fetched word, held until next if_done
- load_or_not  in  1  MEM load request (level)
- store_or_not  in  1  MEM store request (level)
- mem_addr  in  AddrLen  MEM access address
- num_of_bytes  in  3  access size: 3'b001, 3'b010 or 3'b100
- store_data  in  RegLen  store data; low bytes used
- mem_enable  out  1  one-cycle pulse: MEM access complete
- load_data  out  RegLen  raw loaded bytes, zero-extended, held until next load completion
- ram_din  in  8  RAM read data
- ram_dout  out  8  RAM write data
- ram_a  out  AddrLen  RAM byte address
- ram_wr  out  1  RAM write strobe

## Operation
- States are IDLE, READ, WRITE and DONE. Reset state is IDLE.
- Requests are sampled only in IDLE. Priority is store_or_not, then load_or_not, then if_req. If store and load are both high, the access is a store.
- Accept, at the edge ending IDLE cycle 0:
  - Latch base address, n, store_data and the owner (IF or MEM).
  - n = 4 for IF. For MEM, n is taken from the highest set bit of num_of_bytes: 4, 2, else 1. A value of 0 gives n = 1.
  - Go to READ or WRITE.
- Byte order is little-endian. Byte k uses address base+k and bits [8k+7:8k]. Address arithmetic wraps modulo 2^AddrLen.
- RAM contract:
  - An address driven on ram_a in cycle c gives its byte on ram_din in cycle c+1.
  - ram_wr=1 in cycle c writes ram_dout to ram_a at the end of cycle c.
- READ:
  - Keep an issue index i and a capture index j.
  - Each cycle, drive ram_a = base+i and increment i while i < n.
  - Capture ram_din into byte j when a byte is in flight.
  - After byte n-1 is captured, bytes n..3 are zero. Go to DONE.
- WRITE:
  - ram_wr=1 with ram_a = base+k and ram_dout = store_data byte k, for k = 0..n-1 on consecutive cycles.
  - Go to DONE after byte n-1.
- DONE:
  - Pulse if_done or mem_enable for one cycle. Stores also pulse mem_enable.
  - Return to IDLE. Requests present during DONE are ignored.
  - The requester must deassert its request by the DONE cycle.
- Outside READ/WRITE: ram_wr=0, ram_a=0, ram_dout=0.
- rdy low:
  - State, indices, latched request and data registers hold.
  - ram_wr is forced to 0 combinationally.
  - The in-flight read byte is discarded: set i := j.
  - On rdy high, re-issue from byte j. Result data is identical to an unstalled access.
- rst, any time including mid-access:
  - All outputs and registers go to 0 immediately, and the state goes to IDLE. No done pulse is produced.
  - Store bytes already written stay in RAM.

## Timing
- Reset value of every output is 0.
- Cycle 0 is the IDLE cycle whose ending edge accepts the request.
- Read of n bytes:
  - ram_a is driven in cycles 1..n.
  - Bytes are captured at the end of cycles 2..n+1.
  - The done pulse and data are valid in cycle n+2: LW/IF in cycle 6, LH in cycle 4, LB in cycle 3.
- Write of n bytes:
  - ram_wr is high in cycles 1..n.
  - The done pulse is in cycle n+1: SW in cycle 5.
- Back-to-back throughput: the earliest next accept is at the end of cycle done+1.
- Each rdy-low cycle during READ/WRITE adds one cycle of latency. During READ, an in-flight byte additionally costs one re-issue cycle.
- if_data and load_data update on the same edge that raises the corresponding done pulse.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 before the next edge, state IDLE.
- LW: RAM[0x1000..0x1003] = 11,22,33,44, load at 0x1000 with num_of_bytes=3'b100 -> ram_a 0x1000..0x1003 in cycles 1-4, mem_enable in cycle 6, load_data = 0x44332211.
- SH at 0x2002 with store_data=0xDEADBEEF -> ram_wr in cycles 1-2 writing (0x2002,0xEF) then (0x2003,0xBE), mem_enable in cycle 3, RAM[0x2004] unchanged.
- Contention: if_req at 0x0 and LB at 0x10 (RAM=0x80) raised together -> mem_enable first with load_data = 0x00000080, then if_done with the word at 0x0, with no if_done during the MEM access.
- Stall: rdy low for 3 cycles after byte 1 of an LW is captured -> ram_wr stays 0, mem_enable is delayed by 4 cycles, load_data = 0x44332211.
- Reset mid-SW: rst pulse after 2 bytes are written -> no mem_enable, RAM holds bytes 0-1 only; a fresh LW afterwards completes normally in 6 cycles.
